// File: rtl/pwm_cfg_sequencer.sv
// Arbitrates two PWM profile requesters and walks the PWM register command bus
// through stop, period, duty, prescaler, start and a duty readback for each update.
module pwm_cfg_sequencer #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 2,
  parameter int PRE_W          = 3,
  parameter int PERIOD_ADDR    = 0,
  parameter int DUTY_ADDR      = 1,
  parameter int PRESCALER_ADDR = 2,
  parameter int START_ADDR     = 3,
  parameter int READ_LAT       = 2
) (
  input  logic                Clk,
  input  logic                Reset_l,
  input  logic [1:0]          Req,
  input  logic [2*DATA_W-1:0] ReqPeriod,
  input  logic [2*DATA_W-1:0] ReqDuty,
  input  logic [2*PRE_W-1:0]  ReqPrescaler,
  output logic [1:0]          Ack,
  output logic                Err,
  output logic                Busy,
  output logic                CmdVal,
  output logic [ADDR_W-1:0]   CmdAddr,
  output logic [DATA_W-1:0]   CmdDataIn,
  output logic                CmdRW,
  input  logic [DATA_W-1:0]   CmdDataOut
);

  localparam int WCNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(PERIOD_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_DUTY   = ADDR_W'(DUTY_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_PRE    = ADDR_W'(PRESCALER_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_START  = ADDR_W'(START_ADDR);

  typedef enum logic [3:0] {
    IDLE,
    W_STOP,
    W_PER,
    W_DUTY,
    W_PRE,
    W_START,
    RD,
    WAIT,
    DONE
  } state_t;

  state_t              state_q;
  logic                winner_q;
  logic                rrPrio_q;
  logic [DATA_W-1:0]   period_q;
  logic [DATA_W-1:0]   duty_q;
  logic [PRE_W-1:0]    pre_q;
  logic [WCNT_W-1:0]   waitCnt_q;
  logic [1:0]          ack_q;
  logic                err_q;
  logic                busy_q;
  logic                cmdVal_q;
  logic [ADDR_W-1:0]   cmdAddr_q;
  logic [DATA_W-1:0]   cmdData_q;
  logic                cmdRw_q;

  logic                winSel_d;
  logic [DATA_W-1:0]   perSel_d;
  logic [DATA_W-1:0]   dutySel_d;
  logic [DATA_W-1:0]   dutyClamp_d;
  logic [PRE_W-1:0]    preSel_d;

  // rrPrio_q names the requester that wins a tie; a lone request always wins.
  always_comb begin
    winSel_d    = (Req == 2'b11) ? rrPrio_q : Req[1];
    perSel_d    = winSel_d ? ReqPeriod[2*DATA_W-1:DATA_W] : ReqPeriod[DATA_W-1:0];
    dutySel_d   = winSel_d ? ReqDuty[2*DATA_W-1:DATA_W]   : ReqDuty[DATA_W-1:0];
    preSel_d    = winSel_d ? ReqPrescaler[2*PRE_W-1:PRE_W] : ReqPrescaler[PRE_W-1:0];
    dutyClamp_d = (dutySel_d > perSel_d) ? perSel_d : dutySel_d;
  end

  // Bus outputs default to idle each cycle and are set for the state being entered.
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      state_q   <= IDLE;
      winner_q  <= 1'b0;
      rrPrio_q  <= 1'b0;
      period_q  <= '0;
      duty_q    <= '0;
      pre_q     <= '0;
      waitCnt_q <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cmdVal_q  <= 1'b0;
      cmdAddr_q <= '0;
      cmdData_q <= '0;
      cmdRw_q   <= 1'b0;
    end else begin
      cmdVal_q  <= 1'b0;
      cmdAddr_q <= '0;
      cmdData_q <= '0;
      cmdRw_q   <= 1'b0;
      ack_q     <= '0;
      case (state_q)
        IDLE: begin
          if (|Req) begin
            winner_q <= winSel_d;
            period_q <= perSel_d;
            duty_q   <= dutyClamp_d;
            pre_q    <= preSel_d;
            busy_q   <= 1'b1;
            if (perSel_d == '0) begin
              state_q <= DONE;
              ack_q   <= winSel_d ? 2'b10 : 2'b01;
              err_q   <= 1'b1;
            end else begin
              state_q   <= W_STOP;
              cmdVal_q  <= 1'b1;
              cmdAddr_q <= ADDR_START;
            end
          end
        end
        W_STOP: begin
          state_q   <= W_PER;
          cmdVal_q  <= 1'b1;
          cmdAddr_q <= ADDR_PERIOD;
          cmdData_q <= period_q;
        end
        W_PER: begin
          state_q   <= W_DUTY;
          cmdVal_q  <= 1'b1;
          cmdAddr_q <= ADDR_DUTY;
          cmdData_q <= duty_q;
        end
        W_DUTY: begin
          state_q   <= W_PRE;
          cmdVal_q  <= 1'b1;
          cmdAddr_q <= ADDR_PRE;
          cmdData_q <= {{(DATA_W-PRE_W){1'b0}}, pre_q};
        end
        W_PRE: begin
          state_q   <= W_START;
          cmdVal_q  <= 1'b1;
          cmdAddr_q <= ADDR_START;
          cmdData_q <= DATA_W'(1);
        end
        W_START: begin
          state_q   <= RD;
          cmdVal_q  <= 1'b1;
          cmdAddr_q <= ADDR_DUTY;
          cmdRw_q   <= 1'b1;
        end
        RD: begin
          state_q   <= WAIT;
          waitCnt_q <= WCNT_W'(READ_LAT - 1);
        end
        // Readback is sampled on the edge that closes the last WAIT cycle.
        WAIT: begin
          if (waitCnt_q == '0) begin
            state_q <= DONE;
            ack_q   <= winner_q ? 2'b10 : 2'b01;
            err_q   <= (CmdDataOut != duty_q);
          end else begin
            waitCnt_q <= waitCnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          err_q    <= 1'b0;
          rrPrio_q <= ~winner_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Ack       = ack_q;
  assign Err       = err_q;
  assign Busy      = busy_q;
  assign CmdVal    = cmdVal_q;
  assign CmdAddr   = cmdAddr_q;
  assign CmdDataIn = cmdData_q;
  assign CmdRW     = cmdRw_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer with a small PWM register block model.
module tb_pwm_cfg_sequencer;

  logic        Clk;
  logic        Reset_l;
  logic [1:0]  Req;
  logic [31:0] ReqPeriod;
  logic [31:0] ReqDuty;
  logic [5:0]  ReqPrescaler;
  logic [1:0]  Ack;
  logic        Err;
  logic        Busy;
  logic        CmdVal;
  logic [1:0]  CmdAddr;
  logic [15:0] CmdDataIn;
  logic        CmdRW;
  logic [15:0] CmdDataOut;

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] data;
    logic        rw;
  } busTxn_t;

  typedef struct packed {
    logic [1:0] ack;
    logic       err;
  } ackTxn_t;

  busTxn_t busQ[$];
  ackTxn_t ackQ[$];
  busTxn_t monBus;
  ackTxn_t monAck;

  int testsRun;
  int testsFailed;
  int rdOffset;

  logic [15:0] regs [4];
  logic [15:0] rdPipe0;
  logic [15:0] rdPipe1;

  pwm_cfg_sequencer dut (
    .Clk          (Clk),
    .Reset_l      (Reset_l),
    .Req          (Req),
    .ReqPeriod    (ReqPeriod),
    .ReqDuty      (ReqDuty),
    .ReqPrescaler (ReqPrescaler),
    .Ack          (Ack),
    .Err          (Err),
    .Busy         (Busy),
    .CmdVal       (CmdVal),
    .CmdAddr      (CmdAddr),
    .CmdDataIn    (CmdDataIn),
    .CmdRW        (CmdRW),
    .CmdDataOut   (CmdDataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register block model: writes land on the edge, reads return two cycles later.
  always @(posedge Clk) begin
    if (CmdVal === 1'b1 && CmdRW === 1'b0) regs[CmdAddr] <= CmdDataIn;
    if (CmdVal === 1'b1 && CmdRW === 1'b1) rdPipe0 <= regs[CmdAddr] - 16'(rdOffset);
    rdPipe1 <= rdPipe0;
  end
  assign CmdDataOut = rdPipe1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input int who, input logic [15:0] period, input logic [15:0] duty,
                            input logic [2:0] pre, input int offset);
    busTxn_t t;
    ackTxn_t a;
    logic [15:0] clamped;
    clamped = (duty > period) ? period : duty;
    if (period != 16'd0) begin
      t = '{addr: 2'd3, data: 16'd0,        rw: 1'b0}; busQ.push_back(t);
      t = '{addr: 2'd0, data: period,       rw: 1'b0}; busQ.push_back(t);
      t = '{addr: 2'd1, data: clamped,      rw: 1'b0}; busQ.push_back(t);
      t = '{addr: 2'd2, data: {13'd0, pre}, rw: 1'b0}; busQ.push_back(t);
      t = '{addr: 2'd3, data: 16'd1,        rw: 1'b0}; busQ.push_back(t);
      t = '{addr: 2'd1, data: 16'd0,        rw: 1'b1}; busQ.push_back(t);
    end
    a.ack = (who == 1) ? 2'b10 : 2'b01;
    a.err = (period == 16'd0) || (offset != 0);
    ackQ.push_back(a);
  endtask

  task automatic applyStimulus(input int who, input logic [15:0] period, input logic [15:0] duty,
                               input logic [2:0] pre, input int offset);
    pushExpect(who, period, duty, pre, offset);
    rdOffset = offset;
    ReqPeriod[who*16 +: 16]  = period;
    ReqDuty[who*16 +: 16]    = duty;
    ReqPrescaler[who*3 +: 3] = pre;
    Req[who]                 = 1'b1;
  endtask

  task automatic waitAck(input int expCycles, input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (Ack === 2'b00 && cyc < 40);
    checkOutput(tag, 32'(cyc), 32'(expCycles));
    checkOutput({tag, "_busy"}, 32'(Busy), 32'd1);
  endtask

  task automatic finishSeq();
    Req = 2'b00;
    @(negedge Clk);
    checkOutput("busy_clear", 32'(Busy), 32'd0);
  endtask

  // Bus and Ack monitor pops the scoreboard whenever the DUT shows activity.
  always @(negedge Clk) begin
    if (CmdVal === 1'b1) begin
      if (busQ.size() == 0) begin
        checkOutput("bus_unexpected", 32'(CmdVal), 32'd0);
      end else begin
        monBus = busQ.pop_front();
        checkOutput("bus_addr", 32'(CmdAddr), 32'(monBus.addr));
        checkOutput("bus_rw", 32'(CmdRW), 32'(monBus.rw));
        if (!monBus.rw) checkOutput("bus_wdata", 32'(CmdDataIn), 32'(monBus.data));
      end
    end else begin
      checkOutput("bus_idle", 32'({CmdAddr, CmdDataIn, CmdRW}), 32'd0);
    end
    if (Ack !== 2'b00) begin
      if (ackQ.size() == 0) begin
        checkOutput("ack_unexpected", 32'(Ack), 32'd0);
      end else begin
        monAck = ackQ.pop_front();
        checkOutput("ack_vec", 32'(Ack), 32'(monAck.ack));
        checkOutput("ack_err", 32'(Err), 32'(monAck.err));
      end
    end
  end

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rdOffset     = 0;
    Req          = 2'b00;
    ReqPeriod    = '0;
    ReqDuty      = '0;
    ReqPrescaler = '0;
    Reset_l      = 1'b1;
    #2 Reset_l   = 1'b0;
    #1;
    checkOutput("rst_ack", 32'(Ack), 32'd0);
    checkOutput("rst_err", 32'(Err), 32'd0);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_cmdval", 32'(CmdVal), 32'd0);
    checkOutput("rst_bus", 32'({CmdAddr, CmdDataIn, CmdRW}), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_l = 1'b1;
    @(negedge Clk);

    // Both requesters held: 0 wins first after reset, then strict alternation.
    applyStimulus(0, 16'd1000, 16'd500, 3'd1, 0);
    applyStimulus(1, 16'd2000, 16'd100, 3'd4, 0);
    pushExpect(0, 16'd1000, 16'd500, 3'd1, 0);
    pushExpect(1, 16'd2000, 16'd100, 3'd4, 0);
    waitAck(9, "lat_rr0");
    waitAck(10, "lat_rr1");
    waitAck(10, "lat_rr2");
    waitAck(10, "lat_rr3");
    finishSeq();

    applyStimulus(0, 16'd100, 16'd25, 3'd2, 0);
    waitAck(9, "lat_single");
    finishSeq();

    applyStimulus(1, 16'd200, 16'd300, 3'd7, 0);
    waitAck(9, "lat_clamp");
    finishSeq();

    applyStimulus(0, 16'd0, 16'd5, 3'd3, 0);
    waitAck(1, "lat_reject");
    finishSeq();

    applyStimulus(1, 16'd100, 16'd25, 3'd2, 1);
    waitAck(9, "lat_mismatch");
    finishSeq();

    // Max values, then a held Req repeats with a new profile: duty 0, prescaler 0.
    applyStimulus(0, 16'hFFFF, 16'hFFFF, 3'd7, 0);
    @(negedge Clk);
    ReqPeriod[15:0]   = 16'd1;
    ReqDuty[15:0]     = 16'd0;
    ReqPrescaler[2:0] = 3'd0;
    pushExpect(0, 16'd1, 16'd0, 3'd0, 0);
    waitAck(8, "lat_max");
    waitAck(10, "lat_repeat");
    finishSeq();

    // Profile changes and Req drop after acceptance must be ignored.
    applyStimulus(1, 16'd500, 16'd250, 3'd5, 0);
    @(negedge Clk);
    ReqDuty[31:16]   = 16'd999;
    ReqPeriod[31:16] = 16'd7;
    Req              = 2'b00;
    waitAck(8, "lat_stable");
    finishSeq();

    // Reset in W_DUTY abandons the update, then requester 1 is served normally.
    applyStimulus(0, 16'd50, 16'd10, 3'd1, 0);
    repeat (3) @(negedge Clk);
    #2;
    checkOutput("mid_progress", 32'(busQ.size()), 32'd3);
    Reset_l = 1'b0;
    #1;
    checkOutput("mid_cmdval", 32'(CmdVal), 32'd0);
    checkOutput("mid_busy", 32'(Busy), 32'd0);
    Req = 2'b00;
    busQ.delete();
    ackQ.delete();
    @(negedge Clk);
    checkOutput("mid_noack", 32'(Ack), 32'd0);
    @(negedge Clk);
    Reset_l = 1'b1;
    applyStimulus(1, 16'd80, 16'd40, 3'd3, 0);
    waitAck(9, "lat_after_reset");
    finishSeq();

    repeat (3) @(negedge Clk);
    checkOutput("bus_queue_empty", 32'(busQ.size()), 32'd0);
    checkOutput("ack_queue_empty", 32'(ackQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
Arbitrates PWM profile-update requests from two requesters and sequences the PWM register command bus (CmdVal/CmdAddr/CmdDataIn/CmdRW/CmdDataOut) to apply them safely.
Each update runs stop, period, duty, prescaler, start, then reads back duty to verify the write.
Sits between system-level requesters and the PWM register block, and is the only master on that command bus.

Parameters:
DATA_W, 16, command data width and period/duty width
ADDR_W, 2, command address width
PRE_W, 3, prescaler width; CmdDataIn bits above PRE_W are driven 0
PERIOD_ADDR, 0, period register address
DUTY_ADDR, 1, duty register address
PRESCALER_ADDR, 2, prescaler register address
START_ADDR, 3, start register address
READ_LAT, 2, cycles from read-command cycle to valid CmdDataOut

Ports:
Clk  in  1  clock
Reset_l  in  1  reset; asynchronous, active-low
Req  in  2  per-requester update request; level, held until Ack
ReqPeriod  in  2*DATA_W  packed period; requester i at [i*DATA_W +: DATA_W]
ReqDuty  in  2*DATA_W  packed duty, same packing
ReqPrescaler  in  2*PRE_W  packed prescaler
Ack  out  2  one-cycle completion pulse to the served requester
Err  out  1  valid with Ack; 1 = rejected or readback mismatch
Busy  out  1  1 from acceptance until the Ack cycle inclusive
CmdVal  out  1  command valid
CmdAddr  out  ADDR_W  command address
CmdDataIn  out  DATA_W  write data
CmdRW  out  1  1 = read, 0 = write
CmdDataOut  in  DATA_W  read data from the PWM register block

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Reset_l.
- Reset values: all outputs 0. FSM goes to IDLE. Round-robin pointer selects requester 0. Latched profile clears to 0.
- Reset mid-sequence: the bus returns to idle immediately. No Ack is issued, and the partial update is abandoned.
- States: IDLE, W_STOP, W_PER, W_DUTY, W_PRE, W_START, RD, WAIT, DONE.
- Arbitration (IDLE, any Req set):
  - A single request wins outright.
  - If both Req bits are set, the requester not served last wins.
  - After reset, requester 0 wins ties.
  - The winner's period, duty and prescaler are latched on the accepting edge. Later changes or deassertion of Req are ignored.
- Duty clamp: if latched duty > period, duty is replaced by period (100%).
- Period 0: the request is rejected. Go straight to DONE with Err=1. No bus activity.
- Write states: each write state drives CmdVal=1, CmdRW=0 for exactly one cycle, then advances:
  - W_STOP: START_ADDR, data 0
  - W_PER: PERIOD_ADDR, period
  - W_DUTY: DUTY_ADDR, duty
  - W_PRE: PRESCALER_ADDR, prescaler zero-extended
  - W_START: START_ADDR, data 1
- RD: CmdVal=1, CmdRW=1, CmdAddr=DUTY_ADDR for one cycle.
- WAIT: CmdVal=0. Stays READ_LAT cycles. CmdDataOut is sampled on the edge ending the last WAIT cycle.
- DONE:
  - Ack[winner]=1 for one cycle.
  - Err = (sampled value != clamped duty), or 1 for a rejected request.
  - The round-robin pointer records the winner. Next state is IDLE.
- Bus idling: whenever CmdVal=0, drive CmdAddr, CmdDataIn and CmdRW to 0.
- Latency: with acceptance on edge E0, the bus is active in cycles 1–6, WAIT covers cycles 7–8, and Ack is in cycle 9 (READ_LAT=2). A rejected request gives Ack in cycle 1.
- Back-to-back service: a request still pending in the DONE cycle is arbitrated in the following IDLE cycle. The minimum gap between sequences is one IDLE cycle.
- Same-requester repeat: Req still high in the cycle after its Ack is a new request.
- Boundary values:
  - duty = 0 is legal.
  - duty = period is legal.
  - Prescaler 0 is legal.
  - DATA_W maximum values pass through unmodified.

Test Plan:
- Single request: Req=01, period=100, duty=25, prescaler=2 -> writes START=0, PERIOD=100, DUTY=25, PRESCALER=2, START=1, then a read of DUTY_ADDR. With a model returning 25, Ack=01 in cycle 9 and Err=0.
- Simultaneous requests: Req=11 from reset -> requester 0 served first (Ack=01), then requester 1 (Ack=10). With both held after that, service alternates 0,1,0,1.
- Clamp and reject: duty=300, period=200 -> DUTY written as 200, Err=0. Period=0 -> no CmdVal, Ack in cycle 1, Err=1.
- Readback mismatch: the model returns 24 when 25 was written -> Ack with Err=1, and START=1 has still been written.
- Reset mid-sequence: Reset_l low during W_DUTY -> CmdVal=0 asynchronously and no Ack. After release, a new Req=10 is served normally with requester 1 winning.
- Request stability: ReqDuty changed and Req dropped after acceptance -> the originally latched values are written and Ack still pulses.
